fetch_queue: RTL

- Parametrised successor to the single-cycle fetch stage.
- Holds the instruction memory, which is loadable in a program mode.
- Generates sequential PCs and prefetches instructions into a FIFO ahead of decode, using a valid/ready handshake.
- Supports branch redirect with flush, and halt-opcode detection that stops fetch.
- Sits between the program loader / exe-stage redirect and the decode stage of the pipelined core.

---
 rtl/fetch_queue.sv | 130 +++++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// Prefetching fetch stage: loadable instruction memory, sequential PC generation, and a
// credit-counted FIFO toward decode with branch redirect/flush and halt-opcode detection.
module fetch_queue #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned IMEM_DEPTH = 1024,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [5:0]  HALT_OP    = 6'b111111,
    localparam int unsigned AW        = $clog2(IMEM_DEPTH)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            run_i,
    input  logic            prog_we_i,
    input  logic [AW-1:0]   prog_addr_i,
    input  logic [XLEN-1:0] prog_data_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            id_ready_i,
    output logic            id_valid_o,
    output logic [XLEN-1:0] id_ir_o,
    output logic [XLEN-1:0] id_npc_o,
    output logic [XLEN-1:0] pc_out_o,
    output logic            halted_o
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW:0] DepthOcc = (CW+1)'(FIFO_DEPTH);

    logic [XLEN-1:0] mem_q [IMEM_DEPTH];
    logic [XLEN-1:0] rd_data_q;

    logic [XLEN-1:0] fifo_ir_q  [FIFO_DEPTH];
    logic [XLEN-1:0] fifo_npc_q [FIFO_DEPTH];

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] inflight_npc_q, inflight_npc_d;
    logic            inflight_q, inflight_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            halt_seen_q, halt_seen_d;
    logic            halted_q, halted_d;

    logic            redirect_en;
    logic            pop;
    logic            push;
    logic            issue;
    logic [CW:0]     occupancy;

    always_comb begin
        redirect_en = redirect_i & ~halted_q;
        pop         = (count_q != '0) & id_ready_i;
        // A read launched behind a halt, or before a redirect, never reaches the FIFO.
        push        = inflight_q & ~redirect_en & ~halt_seen_q & ~halted_q;
        occupancy   = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
        issue       = run_i & ~halt_seen_q & ~halted_q & ~redirect_en & (occupancy < DepthOcc);
    end

    always_comb begin
        pc_d           = pc_q;
        inflight_d     = issue;
        inflight_npc_d = inflight_npc_q;
        rd_ptr_d       = rd_ptr_q;
        wr_ptr_d       = wr_ptr_q;
        count_d        = count_q + CW'(push) - CW'(pop);
        halt_seen_d    = halt_seen_q | (push & (rd_data_q[31:26] == HALT_OP));
        halted_d       = halted_q | (pop & (fifo_ir_q[rd_ptr_q][31:26] == HALT_OP));

        if (issue) begin
            pc_d           = pc_q + XLEN'(1);
            inflight_npc_d = pc_q + XLEN'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);

        // Pop above still counts toward halted; everything else is flushed.
        if (redirect_en) begin
            pc_d        = redirect_pc_i;
            inflight_d  = 1'b0;
            rd_ptr_d    = '0;
            wr_ptr_d    = '0;
            count_d     = '0;
            halt_seen_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q           <= '0;
            inflight_q     <= 1'b0;
            inflight_npc_q <= '0;
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            count_q        <= '0;
            halt_seen_q    <= 1'b0;
            halted_q       <= 1'b0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                fifo_ir_q[i]  <= '0;
                fifo_npc_q[i] <= '0;
            end
        end else begin
            pc_q           <= pc_d;
            inflight_q     <= inflight_d;
            inflight_npc_q <= inflight_npc_d;
            rd_ptr_q       <= rd_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
            count_q        <= count_d;
            halt_seen_q    <= halt_seen_d;
            halted_q       <= halted_d;
            if (push) begin
                fifo_ir_q[wr_ptr_q]  <= rd_data_q;
                fifo_npc_q[wr_ptr_q] <= inflight_npc_q;
            end
        end
    end

    // Memory contents survive reset; writes and issue are mutually exclusive via run_i.
    always_ff @(posedge clk_i) begin
        if (prog_we_i && !run_i) mem_q[prog_addr_i] <= prog_data_i;
        if (issue) rd_data_q <= mem_q[pc_q[AW-1:0]];
    end

    assign id_valid_o = (count_q != '0);
    assign id_ir_o    = fifo_ir_q[rd_ptr_q];
    assign id_npc_o   = fifo_npc_q[rd_ptr_q];
    assign pc_out_o   = pc_q;
    assign halted_o   = halted_q;

endmodule
